// File: rtl/irrigacao_pkg.sv
// Shared types and constants for the multi-zone irrigation controller:
// zone sequencer states, watering mode encoding and 7-segment glyphs.
package irrigacao_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WATER = 2'd2,
        ST_NEXT  = 2'd3
    } zoneState_t;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'd0,
        MODE_DRIP  = 2'd1,
        MODE_SPRAY = 2'd2
    } waterMode_t;

    // Segment order is {a, b, c, d, e, f, g}, active-high.
    localparam logic [6:0] SEG_H    = 7'b0110111;
    localparam logic [6:0] SEG_M    = 7'b1110110;
    localparam logic [6:0] SEG_L    = 7'b0001110;
    localparam logic [6:0] SEG_E    = 7'b1001111;
    localparam logic [6:0] SEG_A    = 7'b1110111;
    localparam logic [6:0] SEG_G    = 7'b1011110;
    localparam logic [6:0] SEG_ZERO = 7'b1111110;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

endpackage

// File: rtl/debounce_sync.sv
// Single-bit input conditioner: two-flop synchroniser followed by a
// stability counter. The clean output follows the synchronised value only
// after it has held a new level for DEB_CYCLES consecutive cycles.
module debounce_sync #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] stableCnt;

    // Bring the asynchronous input into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count cycles the synchronised level differs from the clean output;
    // any return to the clean level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean     <= 1'b0;
            stableCnt <= '0;
        end else if (sync2 == clean) begin
            stableCnt <= '0;
        end else if (stableCnt == CW'(DEB_CYCLES - 1)) begin
            clean     <= sync2;
            stableCnt <= '0;
        end else begin
            stableCnt <= stableCnt + 1'b1;
        end
    end

endmodule

// File: rtl/irrigacao_multizona_ctrl.sv
// Multi-zone irrigation controller: conditions the tank and climate
// sensors, latches alarm/error, runs the inlet valve with hysteresis and a
// refill timeout, waters zones one at a time round-robin and drives one
// 7-segment digit.
module irrigacao_multizona_ctrl #(
    parameter int  ZONES          = 4,
    parameter int  DEB_CYCLES     = 16,
    parameter int  DRIP_CYCLES    = 1000,
    parameter int  SPRAY_CYCLES   = 400,
    parameter int  REFILL_TIMEOUT = 5000,
    localparam int ZW             = (ZONES > 1) ? $clog2(ZONES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             highLevel,
    input  logic             mediumLevel,
    input  logic             lowLevel,
    input  logic             temperatura,
    input  logic             umidadeAr,
    input  logic [ZONES-1:0] umidadeSolo,
    input  logic             alarmeAck,
    input  logic             chaveSeletora,
    output logic             valvulaEntrada,
    output logic [ZONES-1:0] gotejamento,
    output logic [ZONES-1:0] aspersao,
    output logic [ZW-1:0]    zonaAtiva,
    output logic             erro,
    output logic             alarme,
    output logic [6:0]       seg
);

    import irrigacao_pkg::*;

    localparam int BURST_MAX = (DRIP_CYCLES > SPRAY_CYCLES) ? DRIP_CYCLES : SPRAY_CYCLES;
    localparam int BW        = $clog2(BURST_MAX + 1);
    localparam int RTW       = $clog2(REFILL_TIMEOUT + 1);

    // Debounced sensor values
    logic             hDeb;
    logic             mDeb;
    logic             lDeb;
    logic             tDeb;
    logic             uaDeb;
    logic [ZONES-1:0] usDeb;

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) uDebHigh (
        .clk(clk), .rst_n(rst_n), .raw(highLevel), .clean(hDeb)
    );
    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) uDebMedium (
        .clk(clk), .rst_n(rst_n), .raw(mediumLevel), .clean(mDeb)
    );
    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) uDebLow (
        .clk(clk), .rst_n(rst_n), .raw(lowLevel), .clean(lDeb)
    );
    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) uDebTemp (
        .clk(clk), .rst_n(rst_n), .raw(temperatura), .clean(tDeb)
    );
    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) uDebAir (
        .clk(clk), .rst_n(rst_n), .raw(umidadeAr), .clean(uaDeb)
    );

    for (genvar i = 0; i < ZONES; i++) begin : gSoil
        debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) uDebSoil (
            .clk(clk), .rst_n(rst_n), .raw(umidadeSolo[i]), .clean(usDeb[i])
        );
    end

    // Alarm / error qualification
    logic           eNow;
    logic           alNow;
    logic           refillHit;
    logic           ackValid;
    logic           erroNext;
    logic           alarmeNext;
    logic [RTW-1:0] refillTimer;

    // Level sensors must nest (H implies M implies L); anything else is a
    // sensor fault. An empty tank (L low) is alarming but not an error.
    assign eNow  = (hDeb & ~mDeb) | (mDeb & ~lDeb);
    assign alNow = eNow | ~lDeb;

    // The refill fault fires on the cycle the open valve reaches its limit
    // without the tank reporting full.
    assign refillHit = valvulaEntrada && !hDeb &&
                       (refillTimer == RTW'(REFILL_TIMEOUT - 1));

    // An acknowledge only counts when no set condition is present, so a
    // set in the same cycle always wins.
    assign ackValid   = alarmeAck && !eNow && !alNow && !refillHit;
    assign erroNext   = ackValid ? 1'b0 : (erro | eNow | refillHit);
    assign alarmeNext = ackValid ? 1'b0 : (alarme | alNow | erroNext);

    // Sticky alarm and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            erro   <= 1'b0;
            alarme <= 1'b0;
        end else begin
            erro   <= erroNext;
            alarme <= alarmeNext;
        end
    end

    // Inlet valve with hysteresis between medium and high level; the timer
    // bounds how long a refill may run before it is treated as a fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valvulaEntrada <= 1'b0;
            refillTimer    <= '0;
        end else if (valvulaEntrada) begin
            if (hDeb || erroNext) begin
                valvulaEntrada <= 1'b0;
                refillTimer    <= '0;
            end else begin
                refillTimer <= refillTimer + 1'b1;
            end
        end else if (!mDeb && !erroNext) begin
            valvulaEntrada <= 1'b1;
            refillTimer    <= '0;
        end
    end

    // Zone sequencer signals
    zoneState_t       state;
    waterMode_t       mode;
    logic [BW-1:0]    burst;
    logic [ZONES-1:0] zoneMask;
    logic             zoneNeed;
    logic             wantSpray;
    logic             wantDrip;

    assign zoneMask  = ZONES'(1) << zonaAtiva;
    assign zoneNeed  = ~usDeb[zonaAtiva];
    // Spray on dry air unless it is hot with a low tank; drip on humid air
    // when it is hot or the tank is low.
    assign wantSpray = zoneNeed & ~uaDeb & (~tDeb | mDeb);
    assign wantDrip  = zoneNeed &  uaDeb & ( tDeb | ~mDeb);

    // Round-robin zone sequencer; an active alarm overrides every state and
    // drops the zone valves on the same edge the alarm flag rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mode        <= MODE_NONE;
            burst       <= '0;
            zonaAtiva   <= '0;
            gotejamento <= '0;
            aspersao    <= '0;
        end else if (alarmeNext) begin
            state       <= ST_IDLE;
            mode        <= MODE_NONE;
            gotejamento <= '0;
            aspersao    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (wantSpray) begin
                        aspersao <= zoneMask;
                        mode     <= MODE_SPRAY;
                        burst    <= BW'(SPRAY_CYCLES - 1);
                        state    <= ST_WATER;
                    end else if (wantDrip) begin
                        gotejamento <= zoneMask;
                        mode        <= MODE_DRIP;
                        burst       <= BW'(DRIP_CYCLES - 1);
                        state       <= ST_WATER;
                    end else begin
                        state <= ST_NEXT;
                    end
                end
                ST_WATER: begin
                    if (usDeb[zonaAtiva] || burst == '0) begin
                        gotejamento <= '0;
                        aspersao    <= '0;
                        mode        <= MODE_NONE;
                        state       <= ST_NEXT;
                    end else begin
                        burst <= burst - 1'b1;
                    end
                end
                ST_NEXT: begin
                    zonaAtiva <= (zonaAtiva == ZW'(ZONES - 1)) ? '0 : zonaAtiva + 1'b1;
                    state     <= ST_SCAN;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered display decode: tank level or current watering mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= '0;
        end else if (chaveSeletora) begin
            case (mode)
                MODE_SPRAY: seg <= SEG_A;
                MODE_DRIP:  seg <= SEG_G;
                default:    seg <= SEG_DASH;
            endcase
        end else begin
            case (1'b1)
                erro:    seg <= SEG_E;
                hDeb:    seg <= SEG_H;
                mDeb:    seg <= SEG_M;
                lDeb:    seg <= SEG_L;
                default: seg <= SEG_ZERO;
            endcase
        end
    end

endmodule

// File: tb/tb_irrigacao_multizona_ctrl.sv
// Bench for irrigacao_multizona_ctrl with small timing parameters so every
// scenario completes in a few hundred cycles.
module tb_irrigacao_multizona_ctrl;

    localparam int ZONES  = 4;
    localparam int DEB    = 4;
    localparam int DRIP   = 20;
    localparam int SPRAY  = 12;
    localparam int REFILL = 60;

    localparam logic [6:0] GL_H    = 7'b0110111;
    localparam logic [6:0] GL_M    = 7'b1110110;
    localparam logic [6:0] GL_L    = 7'b0001110;
    localparam logic [6:0] GL_E    = 7'b1001111;
    localparam logic [6:0] GL_A    = 7'b1110111;
    localparam logic [6:0] GL_G    = 7'b1011110;
    localparam logic [6:0] GL_DASH = 7'b0000001;

    logic             clk;
    logic             rst_n;
    logic             highLevel;
    logic             mediumLevel;
    logic             lowLevel;
    logic             temperatura;
    logic             umidadeAr;
    logic [ZONES-1:0] umidadeSolo;
    logic             alarmeAck;
    logic             chaveSeletora;
    logic             valvulaEntrada;
    logic [ZONES-1:0] gotejamento;
    logic [ZONES-1:0] aspersao;
    logic [1:0]       zonaAtiva;
    logic             erro;
    logic             alarme;
    logic [6:0]       seg;

    int compared   = 0;
    int mismatched = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    irrigacao_multizona_ctrl #(
        .ZONES(ZONES), .DEB_CYCLES(DEB), .DRIP_CYCLES(DRIP),
        .SPRAY_CYCLES(SPRAY), .REFILL_TIMEOUT(REFILL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .highLevel(highLevel), .mediumLevel(mediumLevel), .lowLevel(lowLevel),
        .temperatura(temperatura), .umidadeAr(umidadeAr), .umidadeSolo(umidadeSolo),
        .alarmeAck(alarmeAck), .chaveSeletora(chaveSeletora),
        .valvulaEntrada(valvulaEntrada), .gotejamento(gotejamento), .aspersao(aspersao),
        .zonaAtiva(zonaAtiva), .erro(erro), .alarme(alarme), .seg(seg)
    );

    // Scoreboard of expected zone bursts: zone, spray (1) / drip (0), length.
    typedef struct {
        int zone;
        int spray;
        int len;
    } burst_t;

    burst_t expQ[$];
    bit     monEn   = 1'b0;
    bit     inBurst = 1'b0;
    int     curLen;
    int     curZone;
    int     curSpray;

    function automatic int oneHotIdx(input logic [ZONES-1:0] v);
        int r = -1;
        for (int i = 0; i < ZONES; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Burst monitor and exclusivity check on the zone valves.
    always @(negedge clk) begin
        if (rst_n) begin
            compared++;
            if ($countones({gotejamento, aspersao}) > 1) begin
                mismatched++;
                $display("FAIL valve_exclusive: got=%b asp=%b, want at most one bit", gotejamento, aspersao);
            end
            if (monEn) begin
                if (!inBurst && (gotejamento | aspersao) != '0) begin
                    inBurst  = 1'b1;
                    curLen   = 1;
                    curSpray = (aspersao != '0) ? 1 : 0;
                    curZone  = oneHotIdx(gotejamento | aspersao);
                    compared++;
                    if (int'(zonaAtiva) != curZone) begin
                        mismatched++;
                        $display("FAIL burst_zonaAtiva: zonaAtiva=%0d, want %0d", zonaAtiva, curZone);
                    end
                end else if (inBurst && (gotejamento | aspersao) != '0) begin
                    curLen++;
                end else if (inBurst) begin
                    burst_t e;
                    inBurst = 1'b0;
                    compared++;
                    if (expQ.size() == 0) begin
                        mismatched++;
                        $display("FAIL burst_unexpected: zone=%0d spray=%0d len=%0d, want none", curZone, curSpray, curLen);
                    end else begin
                        e = expQ.pop_front();
                        if (curZone != e.zone || curSpray != e.spray || curLen != e.len) begin
                            mismatched++;
                            $display("FAIL burst: zone=%0d spray=%0d len=%0d, want zone=%0d spray=%0d len=%0d",
                                     curZone, curSpray, curLen, e.zone, e.spray, e.len);
                        end
                    end
                end
            end else begin
                inBurst = 1'b0;
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseAck();
        @(negedge clk);
        alarmeAck = 1'b1;
        @(negedge clk);
        alarmeAck = 1'b0;
    endtask

    // Reset asserted mid-cycle, released on a falling edge.
    task automatic applyReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic setupAfterReset(input logic h, input logic m, input logic l,
                                   input logic t, input logic ua, input logic [ZONES-1:0] us);
        highLevel   = h;
        mediumLevel = m;
        lowLevel    = l;
        temperatura = t;
        umidadeAr   = ua;
        umidadeSolo = us;
        applyReset();
        waitCycles(DEB + 6);
    endtask

    task automatic waitQueueEmpty(input string name, input int limit);
        int n = 0;
        while (expQ.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL %s_timeout: %0d bursts outstanding, want 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset();
        #12;
        compared++;
        if ({valvulaEntrada, gotejamento, aspersao, zonaAtiva, erro, alarme, seg} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: valve=%b got=%b asp=%b zona=%0d erro=%b alarme=%b seg=%b, want all 0",
                     valvulaEntrada, gotejamento, aspersao, zonaAtiva, erro, alarme, seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(1);
        // Empty tank after reset: alarm raises, inlet opens.
        compared++;
        if (alarme !== 1'b1 || erro !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_empty_alarm: alarme=%b erro=%b, want 1 0", alarme, erro);
        end
        compared++;
        if (valvulaEntrada !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_empty_valve: valve=%b, want 1", valvulaEntrada);
        end
    endtask

    task automatic test_ack_hold();
        highLevel = 1'b1; mediumLevel = 1'b0; lowLevel = 1'b1;
        waitCycles(DEB + 6);
        compared++;
        if (erro !== 1'b1 || alarme !== 1'b1) begin
            mismatched++;
            $display("FAIL inconsistent_set: erro=%b alarme=%b, want 1 1", erro, alarme);
        end
        compared++;
        if (valvulaEntrada !== 1'b0 || (gotejamento | aspersao) !== '0) begin
            mismatched++;
            $display("FAIL inconsistent_valves: valve=%b zones=%b, want 0", valvulaEntrada, gotejamento | aspersao);
        end
        compared++;
        if (seg !== GL_E) begin
            mismatched++;
            $display("FAIL inconsistent_seg: seg=%b, want %b", seg, GL_E);
        end
        pulseAck();
        waitCycles(2);
        compared++;
        if (erro !== 1'b1 || alarme !== 1'b1) begin
            mismatched++;
            $display("FAIL ack_cause_held: erro=%b alarme=%b, want 1 1", erro, alarme);
        end
        mediumLevel = 1'b1;
        waitCycles(DEB + 6);
        compared++;
        if (erro !== 1'b1 || alarme !== 1'b1) begin
            mismatched++;
            $display("FAIL sticky_after_fix: erro=%b alarme=%b, want 1 1", erro, alarme);
        end
        pulseAck();
        waitCycles(2);
        compared++;
        if (erro !== 1'b0 || alarme !== 1'b0) begin
            mismatched++;
            $display("FAIL ack_clear: erro=%b alarme=%b, want 0 0", erro, alarme);
        end
        compared++;
        if (seg !== GL_H || valvulaEntrada !== 1'b0) begin
            mismatched++;
            $display("FAIL full_tank: seg=%b valve=%b, want %b 0", seg, valvulaEntrada, GL_H);
        end
    endtask

    task automatic test_glitch();
        logic [6:0] want;
        highLevel = 1'b0; mediumLevel = 1'b1; lowLevel = 1'b1;
        waitCycles(DEB + 6);
        compared++;
        if (seg !== GL_M) begin
            mismatched++;
            $display("FAIL level_medium: seg=%b, want %b", seg, GL_M);
        end
        mediumLevel = 1'b0;
        waitCycles(DEB - 1);
        mediumLevel = 1'b1;
        for (int j = 0; j < 2 * DEB + 4; j++) begin
            @(negedge clk);
            compared++;
            if (seg !== GL_M || valvulaEntrada !== 1'b0) begin
                mismatched++;
                $display("FAIL short_glitch[%0d]: seg=%b valve=%b, want %b 0", j, seg, valvulaEntrada, GL_M);
            end
        end
        mediumLevel = 1'b0;
        for (int j = 1; j <= DEB + 3; j++) begin
            @(negedge clk);
            want = (j >= DEB + 3) ? GL_L : GL_M;
            compared++;
            if (seg !== want) begin
                mismatched++;
                $display("FAIL long_pulse_seg[%0d]: seg=%b, want %b", j, seg, want);
            end
            compared++;
            if (valvulaEntrada !== (j >= DEB + 3)) begin
                mismatched++;
                $display("FAIL long_pulse_valve[%0d]: valve=%b, want %b", j, valvulaEntrada, j >= DEB + 3);
            end
        end
        mediumLevel = 1'b1;
        waitCycles(DEB + 6);
        compared++;
        if (valvulaEntrada !== 1'b1 || seg !== GL_M) begin
            mismatched++;
            $display("FAIL hysteresis_hold: valve=%b seg=%b, want 1 %b", valvulaEntrada, seg, GL_M);
        end
        highLevel = 1'b1;
        waitCycles(DEB + 6);
        compared++;
        if (valvulaEntrada !== 1'b0 || seg !== GL_H || erro !== 1'b0) begin
            mismatched++;
            $display("FAIL high_close: valve=%b seg=%b erro=%b, want 0 %b 0", valvulaEntrada, seg, erro, GL_H);
        end
    endtask

    task automatic test_reset_mid_water();
        int n = 0;
        setupAfterReset(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        pulseAck();
        while (aspersao !== 4'b0100 && n < 300) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (aspersao !== 4'b0100 || zonaAtiva !== 2'd2) begin
            mismatched++;
            $display("FAIL reach_zone2_spray: asp=%b zona=%0d, want 0100 2", aspersao, zonaAtiva);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({valvulaEntrada, gotejamento, aspersao, zonaAtiva, erro, alarme, seg} !== '0) begin
            mismatched++;
            $display("FAIL async_reset: asp=%b zona=%0d seg=%b, want all 0", aspersao, zonaAtiva, seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (zonaAtiva !== 2'd0 || aspersao !== '0 || gotejamento !== '0) begin
            mismatched++;
            $display("FAIL after_release: zona=%0d asp=%b got=%b, want 0 0 0", zonaAtiva, aspersao, gotejamento);
        end
    endtask

    task automatic test_drip_round_robin();
        int n = 0;
        setupAfterReset(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0101);
        expQ.push_back('{zone: 1, spray: 0, len: DRIP});
        expQ.push_back('{zone: 3, spray: 0, len: DRIP});
        expQ.push_back('{zone: 1, spray: 0, len: DRIP});
        monEn = 1'b1;
        pulseAck();
        while (gotejamento === '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        waitCycles(3);
        chaveSeletora = 1'b1;
        waitCycles(2);
        compared++;
        if (seg !== GL_G) begin
            mismatched++;
            $display("FAIL drip_seg: seg=%b, want %b", seg, GL_G);
        end
        chaveSeletora = 1'b0;
        waitQueueEmpty("drip", 400);
        monEn = 1'b0;
    endtask

    task automatic test_spray_early_stop();
        int n = 0;
        setupAfterReset(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        expQ.push_back('{zone: 0, spray: 1, len: SPRAY});
        expQ.push_back('{zone: 1, spray: 1, len: SPRAY});
        expQ.push_back('{zone: 2, spray: 1, len: DEB + 5});
        expQ.push_back('{zone: 3, spray: 1, len: SPRAY});
        expQ.push_back('{zone: 0, spray: 1, len: SPRAY});
        monEn = 1'b1;
        pulseAck();
        while (aspersao !== 4'b0100 && n < 300) begin
            @(negedge clk);
            n++;
        end
        waitCycles(2);
        umidadeSolo[2] = 1'b1;
        n = 0;
        while (aspersao !== 4'b1000 && n < 100) begin
            @(negedge clk);
            n++;
        end
        waitCycles(2);
        chaveSeletora = 1'b1;
        waitCycles(2);
        compared++;
        if (seg !== GL_A) begin
            mismatched++;
            $display("FAIL spray_seg: seg=%b, want %b", seg, GL_A);
        end
        chaveSeletora = 1'b0;
        waitQueueEmpty("spray", 400);
        monEn = 1'b0;
    endtask

    task automatic test_refill_timeout();
        int n = 0;
        int guard = 0;
        highLevel = 1'b0; mediumLevel = 1'b0; lowLevel = 1'b1;
        temperatura = 1'b0; umidadeAr = 1'b0; umidadeSolo = '1;
        applyReset();
        while (guard < 300) begin
            @(negedge clk);
            guard++;
            if (valvulaEntrada) begin
                n++;
                if (n == REFILL / 2) begin
                    compared++;
                    if (erro !== 1'b0) begin
                        mismatched++;
                        $display("FAIL refill_midway_erro: erro=%b, want 0", erro);
                    end
                end
            end else if (n > 0) begin
                break;
            end
        end
        compared++;
        if (n != REFILL || valvulaEntrada !== 1'b0) begin
            mismatched++;
            $display("FAIL refill_open_cycles: open=%0d valve=%b, want %0d 0", n, valvulaEntrada, REFILL);
        end
        compared++;
        if (erro !== 1'b1 || alarme !== 1'b1) begin
            mismatched++;
            $display("FAIL refill_fault: erro=%b alarme=%b, want 1 1", erro, alarme);
        end
        waitCycles(1);
        compared++;
        if (seg !== GL_E) begin
            mismatched++;
            $display("FAIL refill_seg: seg=%b, want %b", seg, GL_E);
        end
        chaveSeletora = 1'b1;
        waitCycles(2);
        compared++;
        if (seg !== GL_DASH) begin
            mismatched++;
            $display("FAIL idle_mode_seg: seg=%b, want %b", seg, GL_DASH);
        end
        chaveSeletora = 1'b0;
        pulseAck();
        waitCycles(2);
        compared++;
        if (erro !== 1'b0 || alarme !== 1'b0 || valvulaEntrada !== 1'b1) begin
            mismatched++;
            $display("FAIL refill_ack: erro=%b alarme=%b valve=%b, want 0 0 1", erro, alarme, valvulaEntrada);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        highLevel     = 1'b0;
        mediumLevel   = 1'b0;
        lowLevel      = 1'b0;
        temperatura   = 1'b0;
        umidadeAr     = 1'b0;
        umidadeSolo   = '1;
        alarmeAck     = 1'b0;
        chaveSeletora = 1'b0;

        test_reset();
        test_ack_hold();
        test_glitch();
        test_reset_mid_water();
        test_drip_round_robin();
        test_spray_early_stop();
        test_refill_timeout();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
